// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 command scheduler: arbitrates reset/LED requests, sends frames, checks 0xFA/0xFE replies, retries.
// Latency: grant one cycle after a request is seen in IDLE; done/err one cycle after the deciding reply or timeout.
// Backpressure: requests are levels held until grant; PS2CTRL_BAT_WAIT_EN adds a wait for the 0xAA self-test result after 0xFF.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic       kb_reset_req,
  input  logic       led_req,
  input  logic [2:0] led_state,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_inhibit,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       err
);

`ifdef PS2CTRL_BAT_WAIT_EN
  localparam bit BAT_WAIT = 1'b1;
`else
  localparam bit BAT_WAIT = 1'b0;
`endif

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [CW-1:0] INH_LOAD  = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            tx_oe_q, tx_oe_d;
  logic            idx_q, idx_d;
  logic            bat_q, bat_d;
  logic [1:0]      grant_q, grant_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      byte0_q, byte1_q;
  logic            two_q;
  logic            latch_rst, latch_led, fail;
  logic [2:0]      clk_s;
  logic [1:0]      data_s;
  logic            clk_fall;
  logic [7:0]      cur_byte;
  logic            last_byte;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      clk_s  <= 3'b111;
      data_s <= 2'b11;
    end else begin
      clk_s  <= {clk_s[1:0], ps2_clk_in};
      data_s <= {data_s[0], ps2_data_in};
    end
  end

  assign clk_fall  = clk_s[2] & ~clk_s[1];
  assign cur_byte  = idx_q ? byte1_q : byte0_q;
  assign last_byte = two_q ? idx_q : 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    retry_d   = retry_q;
    tx_oe_d   = tx_oe_q;
    idx_d     = idx_q;
    bat_d     = bat_q;
    grant_d   = 2'b00;
    done_d    = 1'b0;
    err_d     = 1'b0;
    latch_rst = 1'b0;
    latch_led = 1'b0;
    fail      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kb_reset_req || led_req) begin
          grant_d   = kb_reset_req ? 2'b10 : 2'b01;
          latch_rst = kb_reset_req;
          latch_led = ~kb_reset_req;
          state_d   = S_INHIBIT;
          cnt_d     = INH_LOAD;
          retry_d   = '0;
          idx_d     = 1'b0;
          bat_d     = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == '0) state_d = S_REQ;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_REQ: begin
        state_d = S_TX;
        cnt_d   = TMO_LOAD;
        bit_d   = 4'd0;
        tx_oe_d = 1'b1;
      end
      S_TX: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          fail = 1'b1;
        end else if (clk_fall) begin
          // data_oe is the inverse of the line level; parity bit makes the ones count odd
          if (bit_q < 4'd8)       tx_oe_d = ~cur_byte[bit_q[2:0]];
          else if (bit_q == 4'd8) tx_oe_d = ^cur_byte;
          else begin
            tx_oe_d = 1'b0;
            state_d = S_ACK;
          end
          bit_d = bit_q + 4'd1;
        end
      end
      S_ACK: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          fail = 1'b1;
        end else if (clk_fall) begin
          if (!data_s[1]) begin
            state_d = S_WAIT_RESP;
            cnt_d   = TMO_LOAD;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_WAIT_RESP: begin
        cnt_d = cnt_q - CW'(1);
        if (bat_q) begin
          // self-test outcome is final: a bad result is not worth resending 0xFF for
          if (rx_valid && rx_byte == 8'hAA) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if ((rx_valid && rx_byte == 8'hFC) || cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (rx_valid && rx_byte == 8'hFA) begin
          if (!last_byte) begin
            idx_d   = 1'b1;
            retry_d = '0;
            cnt_d   = INH_LOAD;
            state_d = S_INHIBIT;
          end else if (BAT_WAIT && cur_byte == 8'hFF) begin
            bat_d = 1'b1;
            cnt_d = TMO_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if ((rx_valid && rx_byte == 8'hFE) || cnt_q == '0) begin
          fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RW'(1);
        cnt_d   = INH_LOAD;
        state_d = S_INHIBIT;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      retry_q <= '0;
      tx_oe_q <= 1'b0;
      idx_q   <= 1'b0;
      bat_q   <= 1'b0;
      grant_q <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      byte0_q <= 8'h00;
      byte1_q <= 8'h00;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      retry_q <= retry_d;
      tx_oe_q <= tx_oe_d;
      idx_q   <= idx_d;
      bat_q   <= bat_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (latch_rst) begin
        byte0_q <= 8'hFF;
        byte1_q <= 8'h00;
        two_q   <= 1'b0;
      end else if (latch_led) begin
        byte0_q <= 8'hED;
        byte1_q <= {5'b0, led_state};
        two_q   <= 1'b1;
      end
    end
  end

  // Line drives decode straight from state so an async reset releases them at once
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = (state_q == S_REQ) || ((state_q == S_TX) && tx_oe_q);
  assign rx_inhibit  = (state_q == S_INHIBIT) || (state_q == S_REQ) ||
                       (state_q == S_TX) || (state_q == S_ACK);
  assign busy        = (state_q != S_IDLE);
  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with a behavioural PS/2 device on the open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;
  localparam int INH   = 100;
  localparam int TMO   = 1500;
  localparam int RETRY = 3;
  localparam int HALF  = 8;
  localparam int NONE  = -1;

  logic       clk50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_reset_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, done, err;
  logic [1:0] grant;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  always #10 clk50m = ~clk50m;

  ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(RETRY)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .kb_reset_req(kb_reset_req), .led_req(led_req),
    .led_state(led_state), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_inhibit(rx_inhibit), .grant(grant), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Monitor samples just after the active edge
  int   cyc = 0, done_cnt = 0, err_cnt = 0, sends = 0;
  int   inh_run = 0, last_inh = 0, grant_cyc = 0, err_cyc = 0;
  logic clk_oe_prev = 1'b0;
  always begin
    @(posedge clk50m);
    #2;
    cyc++;
    if (grant != 2'b00) grant_cyc = cyc;
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run  = 0;
    end
    if (ps2_clk_oe && !clk_oe_prev) sends++;
    clk_oe_prev = ps2_clk_oe;
  end

  // Device: clocks in 8 data + parity + stop, acks, then replies (low byte, optional high byte)
  logic [7:0] frame_q[$];
  logic       par_q[$];
  logic       stop_q[$];
  int         resp_q[$];
  logic       dev_en = 1'b1;
  logic       dev_busy = 1'b0;
  initial begin
    logic [9:0] bits;
    int r;
    forever begin
      @(negedge clk50m);
      if (dev_en && ps2_data_oe && !ps2_clk_oe) begin
        dev_busy = 1'b1;
        repeat (10) @(negedge clk50m);
        for (int b = 0; b < 10; b++) begin
          dev_clk = 1'b0;
          repeat (HALF) @(negedge clk50m);
          bits[b] = ps2_data_line;
          dev_clk = 1'b1;
          repeat (HALF) @(negedge clk50m);
        end
        dev_data = 1'b0;
        repeat (2) @(negedge clk50m);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk50m);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        frame_q.push_back(bits[7:0]);
        par_q.push_back(bits[8]);
        stop_q.push_back(bits[9]);
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else                   r = 32'h0000_00FA;
        if (r != NONE) begin
          repeat (20) @(negedge clk50m);
          rx_byte  = r[7:0];
          rx_valid = 1'b1;
          @(negedge clk50m);
          rx_valid = 1'b0;
          if (r[15:8] != 8'h00) begin
            repeat (20) @(negedge clk50m);
            rx_byte  = r[15:8];
            rx_valid = 1'b1;
            @(negedge clk50m);
            rx_valid = 1'b0;
          end
        end
        dev_busy = 1'b0;
      end
    end
  end

  task automatic wait_grant(output logic [1:0] g);
    int n = 0;
    while (grant == 2'b00 && n < 5000) begin
      @(negedge clk50m);
      n++;
    end
    g = grant;
  endtask

  task automatic wait_end(input int limit);
    int n = 0;
    while (!(done || err) && n < limit) begin
      @(negedge clk50m);
      n++;
    end
  endtask

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_busy && n < 2000) begin
      @(negedge clk50m);
      n++;
    end
    repeat (10) @(negedge clk50m);
  endtask

  initial begin
    logic [1:0] g;
    int f0, s0, d0, e0, n;

    #25;
    check("rst_outputs", {ps2_clk_oe, ps2_data_oe, rx_inhibit, grant, busy, done, err}, 0);
    @(negedge clk50m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk50m);
    check("idle_busy", busy, 0);

    // 1: LED update 3'b101 -> 0xED, 0x05
    f0 = frame_q.size(); s0 = sends; d0 = done_cnt; e0 = err_cnt;
    led_state = 3'b101;
    led_req   = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    check("t1_grant", g, 2'b01);
    wait_end(10000);
    check("t1_done_err", {done, err}, 2'b10);
    check("t1_inhibit_len", last_inh, INH);
    repeat (5) @(negedge clk50m);
    check("t1_nframes", frame_q.size() - f0, 2);
    check("t1_byte0", frame_q[f0], 8'hED);
    check("t1_par0", par_q[f0], odd_par(8'hED));
    check("t1_stop0", stop_q[f0], 1);
    check("t1_byte1", frame_q[f0+1], 8'h05);
    check("t1_par1", par_q[f0+1], odd_par(8'h05));
    check("t1_sends", sends - s0, 2);
    check("t1_counts", {done_cnt - d0, err_cnt - e0}, {32'd1, 32'd0});
    check("t1_idle_lines", {ps2_clk_oe, ps2_data_oe, busy, rx_inhibit}, 0);

    // 2: simultaneous requests, reset wins then LED follows
    wait_dev_idle();
    f0 = frame_q.size(); d0 = done_cnt;
`ifdef PS2CTRL_BAT_WAIT_EN
    resp_q.push_back(32'h0000_AAFA);
`endif
    led_state    = 3'b010;
    kb_reset_req = 1'b1;
    led_req      = 1'b1;
    wait_grant(g);
    kb_reset_req = 1'b0;
    check("t2_grant_rst", g, 2'b10);
    wait_end(10000);
    check("t2_rst_done", {done, err}, 2'b10);
    @(negedge clk50m);
    wait_grant(g);
    led_req = 1'b0;
    check("t2_grant_led", g, 2'b01);
    wait_end(10000);
    check("t2_led_done", {done, err}, 2'b10);
    repeat (5) @(negedge clk50m);
    check("t2_byte0", frame_q[f0], 8'hFF);
    check("t2_byte1", frame_q[f0+1], 8'hED);
    check("t2_byte2", frame_q[f0+2], 8'h02);
    check("t2_done_cnt", done_cnt - d0, 2);

    // 3a: 0xFE twice then accepted
    wait_dev_idle();
    f0 = frame_q.size(); s0 = sends; e0 = err_cnt;
    resp_q.push_back(32'hFE); resp_q.push_back(32'hFE);
    resp_q.push_back(32'hFA); resp_q.push_back(32'hFA);
    led_state = 3'b001;
    led_req   = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    wait_end(20000);
    check("t3a_done_err", {done, err}, 2'b10);
    repeat (5) @(negedge clk50m);
    check("t3a_sends", sends - s0, 4);
    check("t3a_resend2", frame_q[f0+2], 8'hED);
    check("t3a_byte1", frame_q[f0+3], 8'h01);
    check("t3a_no_err", err_cnt - e0, 0);

    // 3b: always 0xFE -> 1 + MAX_RETRY sends then err
    wait_dev_idle();
    s0 = sends; d0 = done_cnt;
    for (int i = 0; i < 4; i++) resp_q.push_back(32'hFE);
    led_req = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    wait_end(20000);
    check("t3b_done_err", {done, err}, 2'b01);
    repeat (5) @(negedge clk50m);
    check("t3b_sends", sends - s0, 4);
    check("t3b_no_done", done_cnt - d0, 0);

    // 4: device silent -> timeouts, exact retry schedule, err
    wait_dev_idle();
    dev_en = 1'b0;
    s0 = sends;
    led_req = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    wait_end(8000);
    check("t4_done_err", {done, err}, 2'b01);
    check("t4_err_time", err_cyc - grant_cyc, 4 * (INH + 1 + TMO));
    check("t4_sends", sends - s0, 4);
    check("t4_lines", {ps2_clk_oe, ps2_data_oe, busy}, 0);
    dev_en = 1'b1;
    repeat (5) @(negedge clk50m);

    // 5: keyboard reset completion
    f0 = frame_q.size(); s0 = sends;
`ifdef PS2CTRL_BAT_WAIT_EN
    resp_q.push_back(32'h0000_AAFA);
`endif
    kb_reset_req = 1'b1;
    wait_grant(g);
    kb_reset_req = 1'b0;
    check("t5_grant", g, 2'b10);
    wait_end(10000);
    check("t5_done_err", {done, err}, 2'b10);
    repeat (5) @(negedge clk50m);
    check("t5_byte", frame_q[f0], 8'hFF);
`ifdef PS2CTRL_BAT_WAIT_EN
    wait_dev_idle();
    s0 = sends;
    resp_q.push_back(32'h0000_FCFA);
    kb_reset_req = 1'b1;
    wait_grant(g);
    kb_reset_req = 1'b0;
    wait_end(10000);
    check("t5_bat_fail", {done, err}, 2'b01);
    repeat (5) @(negedge clk50m);
`endif
    check("t5_sends", sends - s0, 1);

    // 6: async reset in the middle of a frame
    wait_dev_idle();
    led_state = 3'b011;
    led_req   = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 1000) begin
      @(negedge clk50m);
      n++;
    end
    repeat (60) @(negedge clk50m);
    check("t6_mid_frame", {busy, rx_inhibit, ps2_clk_oe}, 3'b110);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("t6_rst_busy", {busy, rx_inhibit, grant, done, err}, 0);
    repeat (3) @(negedge clk50m);
    rst_n = 1'b1;
    wait_dev_idle();
    f0 = frame_q.size();
    led_state = 3'b110;
    led_req   = 1'b1;
    wait_grant(g);
    led_req = 1'b0;
    check("t6_grant", g, 2'b01);
    wait_end(10000);
    check("t6_done_err", {done, err}, 2'b10);
    repeat (5) @(negedge clk50m);
    check("t6_byte0", frame_q[f0], 8'hED);
    check("t6_byte1", frame_q[f0+1], 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
